link_rx_sched: RTL
==================

LINK_RX_SCHED -- requirements
Module: link_rx_sched

Interface
REQ-001 SHALL have parameter RING_AW, default 6, log2 of words per link ring (64 words).
REQ-002 SHALL have parameter RING_BASE, default 12'hE00, RAM word address of ring 0; ring i base = RING_BASE + i*2^RING_AW.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port link_dor, input, 4, per-link receive data-ready flag.
REQ-006 SHALL have port link_dout, input, 128, receive words; link i occupies bits [32i+31:32i].
REQ-007 SHALL have port link_cs, output, 4, one-hot link chip select.
REQ-008 SHALL have port link_rd, output, 1, read strobe qualifying link_cs.
REQ-009 SHALL have port ram_req, output, 1, RAM write-port request.
REQ-010 SHALL have port ram_gnt, input, 1, RAM grant; write takes effect on a rising edge where ram_req and ram_gnt are both high.
REQ-011 SHALL have ports ram_addr (output, 12, word address), ram_din (output, 32, write data) and ram_we (output, 1, write enable).
REQ-012 SHALL have port cpu_rptr, input, 4*RING_AW, per-ring CPU read pointers, which the CPU owns.
REQ-013 SHALL have port wptr, output, 4*RING_AW, per-ring write pointers.
REQ-014 SHALL have port ring_full, output, 4, per-ring full flags.

Function
REQ-015 SHALL treat link i as eligible when link_dor[i]=1 and ring_full[i]=0.
REQ-016 SHALL assert ring_full[i] combinationally when (wptr[i]+1) mod 2^RING_AW == cpu_rptr[i]; the design keeps one slot always empty.
REQ-017 SHALL implement the FSM states IDLE, READ and WRITE.
REQ-018 SHALL, in IDLE with at least one eligible link, select the eligible link nearest at or after rr_ptr in the order 0..3 with wrap, latch it as g, and go to READ.
REQ-019 SHALL, in READ, drive link_cs[g]=1 and link_rd=1 for exactly one cycle, capture link_dout slice g into a data register at the end of that cycle, and go to WRITE.
REQ-020 SHALL, in WRITE, hold ram_req=1, ram_we=1, ram_addr=ring base g + wptr[g] and ram_din=captured word until ram_gnt is sampled high.
REQ-021 SHALL, on the grant edge in WRITE, increment wptr[g] modulo 2^RING_AW, set rr_ptr=(g+1) mod 4, and return to IDLE.
REQ-022 SHALL give a minimum service time of 3 cycles per word (IDLE, READ, WRITE with an immediate grant).
REQ-023 SHALL leave an ineligible link's data unread, so that its ready flag remains asserted and the link's flow control back-pressures the sender; no data is dropped.
REQ-024 SHALL evaluate eligibility only in IDLE; a cpu_rptr change during READ or WRITE does not abort the transfer in progress.
REQ-025 SHALL drive link_cs, link_rd, ram_req and ram_we to 0 in every state other than those specified above.

Reset
REQ-026 SHALL, while resetb=0, force state=IDLE, rr_ptr=0, all wptr=0, data register=0 and all outputs to 0; ring_full then follows from cpu_rptr.
REQ-027 SHALL abandon any READ or WRITE in progress when reset is asserted, with no RAM write and no pointer increment.

Configuration
REQ-028 SHALL, when LINK_RX_SCHED_IRQ_EN is defined, add input irq_mask (4 bits) and output irq (1 bit), registered, with irq = OR over i of (wptr[i]!=cpu_rptr[i] & irq_mask[i]) and irq reset to 0.
REQ-029 SHALL omit the irq and irq_mask ports when LINK_RX_SCHED_IRQ_EN is undefined, with all other behaviour unchanged.

Structure
REQ-030 SHALL place NLINKS=4, the state enum and the default RING_BASE in shared package link_sched_pkg.
REQ-031 SHALL implement the round-robin selection as sub-module rr_arb4, with inputs req[3:0] and ptr[1:0] and outputs gnt[3:0] (one-hot) and any.

Verification
REQ-032 SHALL cover: link_dor=4'b0100, ram_gnt tied to 1, link word 32'hDEADBEEF -> link_cs=4'b0100 for 1 cycle; write to address 12'hE80 with data DEADBEEF; wptr[2]=1.
REQ-033 SHALL cover: all link_dor held at 1, ram_gnt tied to 1 -> links serviced in order 0,1,2,3,0 with 3 cycles per word.
REQ-034 SHALL cover: ram_gnt held low for 5 cycles in WRITE -> ram_req, ram_addr and ram_din stable throughout, and a single write when the grant arrives.
REQ-035 SHALL cover: ring 1 with cpu_rptr=0 and 63 words written -> ring_full[1]=1, link 1 not read while link_dor[1] stays high; advancing cpu_rptr to 1 resumes service.
REQ-036 SHALL cover: wptr[0]=63 and one more word -> write to address 12'hE3F, then wptr[0] wraps to 0.
REQ-037 SHALL cover: resetb pulsed low during WRITE -> no write occurs, wptr unchanged at 0, and state is IDLE after reset release.

Source files
------------

// File: rtl/link_sched_pkg.sv
// Shared types and constants for the link receive scheduler.
// Holds the link count, FSM state encoding and default ring placement.
package link_sched_pkg;

    localparam int NLINKS = 4;

    localparam logic [11:0] RING_BASE_DEF = 12'hE00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } sched_state_t;

    function automatic logic [1:0] onehot_idx(input logic [NLINKS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NLINKS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/link_rx_sched_rr_arb4.sv
// Four-way round-robin arbiter: grants the first request at or after ptr.
// Purely combinational; the scheduler owns the pointer register.
module rr_arb4
    import link_sched_pkg::*;
(
    input  logic [NLINKS-1:0] req,
    input  logic [1:0]        ptr,
    output logic [NLINKS-1:0] gnt,
    output logic              any
);

    logic [1:0] idx;

    // Walk from farthest to nearest so the nearest request wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NLINKS - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) gnt = 4'b0001 << idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/link_rx_sched.sv
// Moves words from four receive links into per-link RAM rings.
// Optional LINK_RX_SCHED_IRQ_EN adds irq_mask/irq (ring-not-empty interrupt).
module link_rx_sched
    import link_sched_pkg::*;
#(
    parameter int          RING_AW   = 6,
    parameter logic [11:0] RING_BASE = RING_BASE_DEF
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic [NLINKS-1:0]         link_dor,
    input  logic [32*NLINKS-1:0]      link_dout,
    output logic [NLINKS-1:0]         link_cs,
    output logic                      link_rd,
    output logic                      ram_req,
    input  logic                      ram_gnt,
    output logic [11:0]               ram_addr,
    output logic [31:0]               ram_din,
    output logic                      ram_we,
    input  logic [NLINKS*RING_AW-1:0] cpu_rptr,
    output logic [NLINKS*RING_AW-1:0] wptr,
`ifdef LINK_RX_SCHED_IRQ_EN
    input  logic [NLINKS-1:0]         irq_mask,
    output logic                      irq,
`endif
    output logic [NLINKS-1:0]         ring_full
);

    sched_state_t       state;
    logic [1:0]         g;
    logic [1:0]         rr_ptr;
    logic [RING_AW-1:0] wptr_q [NLINKS];
    logic [31:0]        data_q;
    logic [NLINKS-1:0]  eligible;
    logic [NLINKS-1:0]  arb_gnt;
    logic               arb_any;
    logic [1:0]         sel;
    logic [31:0]        rd_word;
    logic [11:0]        wr_addr;

    // One slot stays empty so full and empty are distinguishable.
    for (genvar i = 0; i < NLINKS; i++) begin : g_ring
        logic [RING_AW-1:0] nxt;
        assign nxt = wptr_q[i] + RING_AW'(1);
        assign ring_full[i] = (nxt == cpu_rptr[i*RING_AW +: RING_AW]);
        assign wptr[i*RING_AW +: RING_AW] = wptr_q[i];
    end

    assign eligible = link_dor & ~ring_full;

    rr_arb4 u_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    assign sel     = onehot_idx(arb_gnt);
    assign rd_word = link_dout[32*g +: 32];
    assign wr_addr = RING_BASE + (12'(g) << RING_AW) + 12'(wptr_q[g]);
    assign ram_din = data_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            g        <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NLINKS; i++) wptr_q[i] <= '0;
            data_q   <= '0;
            link_cs  <= '0;
            link_rd  <= 1'b0;
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        g       <= sel;
                        link_cs <= arb_gnt;
                        link_rd <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    link_cs  <= '0;
                    link_rd  <= 1'b0;
                    data_q   <= rd_word;
                    ram_addr <= wr_addr;
                    ram_req  <= 1'b1;
                    ram_we   <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (ram_gnt) begin
                        wptr_q[g] <= wptr_q[g] + RING_AW'(1);
                        rr_ptr    <= g + 2'd1;
                        ram_req   <= 1'b0;
                        ram_we    <= 1'b0;
                        ram_addr  <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    link_cs <= '0;
                    link_rd <= 1'b0;
                    ram_req <= 1'b0;
                    ram_we  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef LINK_RX_SCHED_IRQ_EN
    logic [NLINKS-1:0] pend;

    for (genvar i = 0; i < NLINKS; i++) begin : g_pend
        assign pend[i] = wptr_q[i] != cpu_rptr[i*RING_AW +: RING_AW];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) irq <= 1'b0;
        else         irq <= |(pend & irq_mask);
    end
`endif

endmodule
